// File: rtl/bpsk_defs_pkg.sv
// bpsk_defs: frame constants and state encodings shared by the BPSK transmitter and receiver.
package bpsk_defs;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
    localparam logic [7:0] LEN_ADDR = 8'd0;
    localparam logic [7:0] PAY_BASE = 8'd1;
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, DONE} state_t;
endpackage

// File: rtl/bpsk_sync_detect.sv
// bpsk_sync_detect: MSB-first sync-word hunter with a fill counter so stale register
// contents can never produce a match right after a clear.
module bpsk_sync_detect #(
    parameter int SYNC_W = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(16'hEB90)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic sync_hit
);
    localparam int FW = $clog2(SYNC_W + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_W);
    localparam logic [FW-1:0] FILL_HIT = FW'(SYNC_W - 1);
    logic [SYNC_W-1:0] sr;
    logic [SYNC_W-1:0] nxt;
    logic [FW-1:0] fill;
    assign nxt = {sr[SYNC_W-2:0], bit_in};
    // fill counts bits before this one, so the current bit completes the window
    assign sync_hit = bit_valid && !clear && nxt == SYNC_WORD && fill >= FILL_HIT;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr <= '0;
            fill <= '0;
        end else if (bit_valid) begin
            sr <= nxt;
            fill <= fill == FILL_MAX ? fill : fill + FW'(1);
        end
    end
endmodule

// File: rtl/bpsk_rx_framer.sv
// bpsk_rx_framer: sync hunt, length/payload deserializer and RAM writer for received BPSK frames.
module bpsk_rx_framer
    import bpsk_defs::*;
#(
    parameter int SYNC_W = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
    parameter int ADDR_W = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              ram_clk,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wr_data,
    output logic              ram_rst,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_len,
    output logic              frame_err
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);
    state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] sh;
    logic [7:0] len, idx, byte_val;
    logic [IW-1:0] idle;
    logic wr, sync_hit, byte_done;
    bpsk_sync_detect #(.SYNC_W(SYNC_W), .SYNC_WORD(SYNC_WORD)) u_sync (
        .clk(clk),
        .rst(rst),
        .clear(state != HUNT),
        .bit_valid(bit_valid),
        .bit_in(bit_in),
        .sync_hit(sync_hit)
    );
    assign byte_val = {sh, bit_in};
    assign byte_done = bit_valid && bit_cnt == 3'd7;
    assign ram_clk = clk;
    assign ram_rst = 1'b0;
    assign ram_en = wr;
    assign ram_we = wr;
    assign busy = state != HUNT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            bit_cnt <= '0;
            sh <= '0;
            len <= '0;
            idx <= '0;
            idle <= '0;
            wr <= 1'b0;
            ram_addr <= '0;
            ram_wr_data <= '0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            frame_len <= '0;
        end else begin
            wr <= 1'b0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                HUNT: if (sync_hit) begin
                    state <= LEN;
                    bit_cnt <= '0;
                    idle <= '0;
                end
                LEN, PAYLOAD: if (bit_valid) begin
                    idle <= '0;
                    bit_cnt <= bit_cnt + 3'd1;
                    sh <= byte_val[6:0];
                    if (byte_done && state == LEN) begin
                        if (byte_val == 8'd0) begin
                            frame_err <= 1'b1;
                            state <= HUNT;
                        end else begin
                            wr <= 1'b1;
                            ram_addr <= ADDR_W'(LEN_ADDR);
                            ram_wr_data <= byte_val;
                            len <= byte_val;
                            idx <= '0;
                            state <= PAYLOAD;
                        end
                    end else if (byte_done) begin
                        wr <= 1'b1;
                        ram_addr <= ADDR_W'(idx + PAY_BASE);
                        ram_wr_data <= byte_val;
                        idx <= idx + 8'd1;
                        if (idx == len - 8'd1) state <= DONE;
                    end
                end else if (idle == IDLE_MAX) begin
                    frame_err <= 1'b1;
                    state <= HUNT;
                end else begin
                    idle <= idle + IW'(1);
                end
                DONE: begin
                    frame_done <= 1'b1;
                    frame_len <= len;
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule
